// File: rtl/stream_arbiter_wrr.sv
// Weighted round-robin stream arbiter: zero-latency grant, per-input
// credit bursts, grant frozen while the sink back-pressures.
module stream_arbiter_wrr #(
    parameter type DATA_T   = logic,
    parameter int  N_INP    = 4,
    parameter int  WEIGHT_W = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [N_INP*WEIGHT_W-1:0]    weight_i,
    input  DATA_T                        inp_data_i [N_INP],
    input  logic [N_INP-1:0]             inp_valid_i,
    output logic [N_INP-1:0]             inp_ready_o,
    output DATA_T                        oup_data_o,
    output logic                         oup_valid_o,
    input  logic                         oup_ready_i,
    output logic [$clog2(N_INP)-1:0]     oup_idx_o
);

    localparam int IW = $clog2(N_INP);
    localparam logic [IW-1:0] LAST = IW'(N_INP - 1);

    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       lk_q, lk_d;
    logic [WEIGHT_W-1:0] cred_q, cred_d;
    logic                lock_q, lock_d;

    logic [IW-1:0]       idx;
    logic [IW-1:0]       cand;
    logic [WEIGHT_W-1:0] wsel;
    logic                en;
    logic                hs;

    // Walk offsets high to low so the nearest valid after ptr wins; ptr is last.
    always_comb begin
        idx  = ptr_q;
        cand = ptr_q;
        if (lock_q) begin
            idx = lk_q;
        end else if (inp_valid_i[ptr_q] && cred_q != '0) begin
            idx = ptr_q;
        end else begin
            for (int i = N_INP; i >= 1; i--) begin
                cand = IW'((int'(ptr_q) + i) % N_INP);
                if (inp_valid_i[cand]) begin
                    idx = cand;
                end
            end
        end
    end

    assign en          = !rst_i && !flush_i;
    assign oup_idx_o   = idx;
    assign oup_data_o  = inp_data_i[idx];
    assign oup_valid_o = en && inp_valid_i[idx];
    assign hs          = oup_valid_o && oup_ready_i;
    assign wsel        = weight_i[int'(idx)*WEIGHT_W +: WEIGHT_W];

    always_comb begin
        inp_ready_o      = '0;
        inp_ready_o[idx] = hs;
    end

    always_comb begin
        ptr_d  = ptr_q;
        cred_d = cred_q;
        lock_d = lock_q;
        lk_d   = lk_q;
        if (flush_i) begin
            ptr_d  = LAST;
            cred_d = '0;
            lock_d = 1'b0;
        end else if (hs) begin
            lock_d = 1'b0;
            if (idx == ptr_q && cred_q != '0) begin
                cred_d = cred_q - 1'b1;
            end else begin
                ptr_d  = idx;
                cred_d = (wsel == '0) ? '0 : wsel - 1'b1;
            end
        end else if (oup_valid_o) begin
            lock_d = 1'b1;
            lk_d   = idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q  <= LAST;
            cred_q <= '0;
            lock_q <= 1'b0;
            lk_q   <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cred_q <= cred_d;
            lock_q <= lock_d;
            lk_q   <= lk_d;
        end
    end

    a_lock_valid : assert property (@(posedge clk_i) disable iff (rst_i)
        (lock_q && !flush_i) |-> inp_valid_i[lk_q])
        else $error("locked input dropped valid");

endmodule

// File: tb/tb_stream_arbiter_wrr.sv
// Directed bench for stream_arbiter_wrr: vector table for steady-state
// sequences plus hand sequences for lock, flush and reset corners.
module tb_stream_arbiter_wrr;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [15:0] weight_i = '0;
    logic [7:0]  inp_data_i [4];
    logic [3:0]  inp_valid_i = '0;
    logic [3:0]  inp_ready_o;
    logic [7:0]  oup_data_o;
    logic        oup_valid_o;
    logic        oup_ready_i = 1'b0;
    logic [1:0]  oup_idx_o;

    int errors = 0;
    int checks = 0;

    stream_arbiter_wrr #(
        .DATA_T(logic [7:0]),
        .N_INP(4),
        .WEIGHT_W(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush_i(flush_i),
        .weight_i(weight_i),
        .inp_data_i(inp_data_i),
        .inp_valid_i(inp_valid_i),
        .inp_ready_o(inp_ready_o),
        .oup_data_o(oup_data_o),
        .oup_valid_o(oup_valid_o),
        .oup_ready_i(oup_ready_i),
        .oup_idx_o(oup_idx_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic [15:0] wt;
        logic [3:0]  vld;
        logic        rdy;
        logic [1:0]  e_idx;
        logic        e_vld;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic r, logic [15:0] w, logic [3:0] v,
                                logic rd, logic [1:0] ei, logic ev);
        vec_t x;
        x.rst = r; x.wt = w; x.vld = v; x.rdy = rd;
        x.e_idx = ei; x.e_vld = ev;
        return x;
    endfunction

    function automatic logic [3:0] onehot(logic [1:0] i, logic on);
        logic [3:0] r;
        r = '0;
        if (on) r[i] = 1'b1;
        return r;
    endfunction

    task automatic do_reset();
        inp_valid_i = 4'hF;
        oup_ready_i = 1'b1;
        flush_i     = 1'b0;
        rst_i       = 1'b1;
        #1;
        chk("rst_valid", 32'(oup_valid_o), 0);
        chk("rst_ready", 32'(inp_ready_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Checks the combinational grant mid-cycle, then advances one edge.
    task automatic expect_grant(string nm, logic [1:0] ei, logic ev);
        @(negedge clk_i);
        chk({nm, "_idx"}, 32'(oup_idx_o), 32'(ei));
        chk({nm, "_valid"}, 32'(oup_valid_o), 32'(ev));
        chk({nm, "_ready"}, 32'(inp_ready_o), 32'(onehot(ei, ev && oup_ready_i)));
        if (ev) chk({nm, "_data"}, 32'(oup_data_o), 32'(8'hA0 + ei));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) inp_data_i[k] = 8'(8'hA0 + k);

        // reset then idle: idx parks at N_INP-1
        tbl.push_back(mk(1, 16'h1111, 4'h0, 1, 2'd3, 0));
        // weights {1,2,3,1}, all valid
        tbl.push_back(mk(1, 16'h1321, 4'hF, 1, 2'd0, 1));
        tbl.push_back(mk(0, 16'h1321, 4'hF, 1, 2'd1, 1));
        tbl.push_back(mk(0, 16'h1321, 4'hF, 1, 2'd1, 1));
        tbl.push_back(mk(0, 16'h1321, 4'hF, 1, 2'd2, 1));
        tbl.push_back(mk(0, 16'h1321, 4'hF, 1, 2'd2, 1));
        tbl.push_back(mk(0, 16'h1321, 4'hF, 1, 2'd2, 1));
        tbl.push_back(mk(0, 16'h1321, 4'hF, 1, 2'd3, 1));
        tbl.push_back(mk(0, 16'h1321, 4'hF, 1, 2'd0, 1));
        tbl.push_back(mk(0, 16'h1321, 4'hF, 1, 2'd1, 1));
        tbl.push_back(mk(0, 16'h1321, 4'hF, 1, 2'd1, 1));
        // weights all 2, only inputs 1 and 3 valid
        tbl.push_back(mk(1, 16'h2222, 4'hA, 1, 2'd1, 1));
        tbl.push_back(mk(0, 16'h2222, 4'hA, 1, 2'd1, 1));
        tbl.push_back(mk(0, 16'h2222, 4'hA, 1, 2'd3, 1));
        tbl.push_back(mk(0, 16'h2222, 4'hA, 1, 2'd3, 1));
        tbl.push_back(mk(0, 16'h2222, 4'hA, 1, 2'd1, 1));
        tbl.push_back(mk(0, 16'h2222, 4'hA, 1, 2'd1, 1));
        // weights {2,0,2,2}: zero weight gives one grant per round
        tbl.push_back(mk(1, 16'h2202, 4'hF, 1, 2'd0, 1));
        tbl.push_back(mk(0, 16'h2202, 4'hF, 1, 2'd0, 1));
        tbl.push_back(mk(0, 16'h2202, 4'hF, 1, 2'd1, 1));
        tbl.push_back(mk(0, 16'h2202, 4'hF, 1, 2'd2, 1));
        tbl.push_back(mk(0, 16'h2202, 4'hF, 1, 2'd2, 1));
        tbl.push_back(mk(0, 16'h2202, 4'hF, 1, 2'd3, 1));
        tbl.push_back(mk(0, 16'h2202, 4'hF, 1, 2'd3, 1));
        tbl.push_back(mk(0, 16'h2202, 4'hF, 1, 2'd0, 1));
        tbl.push_back(mk(0, 16'h2202, 4'hF, 1, 2'd0, 1));
        tbl.push_back(mk(0, 16'h2202, 4'hF, 1, 2'd1, 1));
        // nothing valid: idx reports ptr (last owner 1)
        tbl.push_back(mk(0, 16'h2202, 4'h0, 1, 2'd1, 0));

        @(posedge clk_i);
        #1;
        foreach (tbl[n]) begin
            if (tbl[n].rst) do_reset();
            weight_i    = tbl[n].wt;
            inp_valid_i = tbl[n].vld;
            oup_ready_i = tbl[n].rdy;
            expect_grant($sformatf("vec%0d", n), tbl[n].e_idx, tbl[n].e_vld);
        end

        // lock: input 2 stalled, input 0 arrives, grant must not move
        do_reset();
        weight_i    = 16'h1111;
        inp_valid_i = 4'b0100;
        oup_ready_i = 1'b0;
        expect_grant("lock_c0", 2'd2, 1);
        expect_grant("lock_c1", 2'd2, 1);
        inp_valid_i = 4'b0101;
        inp_data_i[0] = 8'hA0;
        expect_grant("lock_c2", 2'd2, 1);
        oup_ready_i = 1'b1;
        expect_grant("lock_hs", 2'd2, 1);
        inp_valid_i = 4'b0001;
        expect_grant("lock_next", 2'd0, 1);

        // flush after one handshake restores a full burst for input 0
        do_reset();
        weight_i    = 16'h1113;
        inp_valid_i = 4'b0001;
        oup_ready_i = 1'b1;
        expect_grant("fl_pre", 2'd0, 1);
        flush_i     = 1'b1;
        inp_valid_i = 4'hF;
        @(negedge clk_i);
        chk("fl_valid", 32'(oup_valid_o), 0);
        chk("fl_ready", 32'(inp_ready_o), 0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        expect_grant("fl_g0", 2'd0, 1);
        expect_grant("fl_g1", 2'd0, 1);
        expect_grant("fl_g2", 2'd0, 1);
        expect_grant("fl_g3", 2'd1, 1);

        // reset while locked on input 3
        do_reset();
        weight_i    = 16'h1111;
        inp_valid_i = 4'b1000;
        oup_ready_i = 1'b0;
        expect_grant("rl_c0", 2'd3, 1);
        inp_valid_i = 4'b1001;
        expect_grant("rl_c1", 2'd3, 1);
        @(negedge clk_i);
        oup_ready_i = 1'b1;
        rst_i       = 1'b1;
        #1;
        chk("rl_valid", 32'(oup_valid_o), 0);
        chk("rl_ready", 32'(inp_ready_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        expect_grant("rl_after", 2'd0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stream_arbiter_wrr.md
STREAM_ARBITER_WRR -- requirements
Module: stream_arbiter_wrr

Interface
REQ-001 SHALL have parameter DATA_T, default logic: payload type of every stream.
REQ-002 SHALL have parameter N_INP, default 4: number of input streams, legal range 2..64.
REQ-003 SHALL have parameter WEIGHT_W, default 4: width of each per-input weight field.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port flush_i, input, 1: synchronous clear of arbitration state.
REQ-007 SHALL have port weight_i, input, N_INP*WEIGHT_W: weight of input k in bits [k*WEIGHT_W +: WEIGHT_W].
REQ-008 SHALL have port inp_data_i, input, N_INP x DATA_T: input payloads.
REQ-009 SHALL have port inp_valid_i, input, N_INP: input valids.
REQ-010 SHALL have port inp_ready_o, output, N_INP: input readies.
REQ-011 SHALL have port oup_data_o, output, DATA_T: granted payload.
REQ-012 SHALL have port oup_valid_o, output, 1: output valid.
REQ-013 SHALL have port oup_ready_i, input, 1: output ready.
REQ-014 SHALL have port oup_idx_o, output, clog2(N_INP): index of the granted input.

Function
REQ-015 SHALL hold state: ptr (current owner index), cred (remaining grants for the owner, WEIGHT_W bits) and lock (grant frozen).
REQ-016 SHALL compute the grant combinationally with zero-cycle latency: oup_data_o = inp_data_i[idx], oup_valid_o = inp_valid_i[idx], inp_ready_o one-hot at idx gated by oup_ready_i, all other bits 0.
REQ-017 SHALL, when lock=1, keep idx equal to the locked index regardless of other valids.
REQ-018 SHALL, when lock=0, select idx = ptr if inp_valid_i[ptr]=1 and cred>0; otherwise the first valid input searching ptr+1, ptr+2, ... wrapping modulo N_INP, with ptr itself checked last.
REQ-019 SHALL, when no input is valid, drive oup_valid_o=0, oup_idx_o=ptr and inp_ready_o=0.
REQ-020 SHALL, on a handshake (oup_valid_o and oup_ready_i) with idx=ptr and cred>0, decrement cred by 1.
REQ-021 SHALL, on any other handshake, set ptr to idx and load cred with weff(idx)-1, where weff is weight_i[idx], except that weight 0 counts as 1.
REQ-022 SHALL sample weight_i only on a reload; weight changes do not affect the credit already in use.
REQ-023 SHALL set lock=1 when oup_valid_o=1 and oup_ready_i=0, and clear lock on the handshake cycle.
REQ-024 SHALL keep oup_data_o and oup_idx_o stable while locked, provided inputs obey valid/ready rules.
REQ-025 SHALL include a simulation-only assertion that flags inp_valid_i[idx] falling while lock=1.
REQ-026 SHALL, while flush_i=1, force oup_valid_o=0 and inp_ready_o=0, and at the clock edge set ptr=N_INP-1, cred=0 and lock=0.
REQ-027 SHALL give flush_i priority over any handshake evaluated in the same cycle.

Reset
REQ-028 SHALL, while rst_i=1, asynchronously set ptr=N_INP-1, cred=0 and lock=0, and force oup_valid_o=0 and inp_ready_o=0.
REQ-029 SHALL start the first post-reset search at input 0.
REQ-030 SHALL allow reset mid-transfer, abandoning any locked grant with no further output.

Verification (N_INP=4, WEIGHT_W=4)
REQ-031 SHALL cover: weights {1,2,3,1}, all valid, oup_ready_i=1 -> oup_idx_o sequence 0,1,1,2,2,2,3,0,1,1.
REQ-032 SHALL cover: only input 2 valid, ready=0 for 3 cycles, input 0 valid from cycle 2 -> idx stays 2 with data constant, handshake on 2, then grant 0.
REQ-033 SHALL cover: weights all 2, only inputs 1 and 3 valid, ready=1 -> sequence 1,1,3,3,1,1; inp_ready_o never set for inputs 0 or 2.
REQ-034 SHALL cover: weight 0 on input 1, all valid -> input 1 gets exactly 1 grant per round.
REQ-035 SHALL cover: w0=3, one handshake on input 0, then flush_i for 1 cycle -> oup_valid_o=0 during flush; next grant is input 0 with a full 3 credits.
REQ-036 SHALL cover: rst_i asserted while locked on input 3 -> oup_valid_o=0 and inp_ready_o=0 immediately; after release the first grant is the lowest valid index.
